timer_periph_slave: RTL and testbench

- Memory-mapped peripheral responder on the CPU's load/store bus.
- The CPU is the initiator: it drives rd/wr/addr/wdata and samples rdata in the same cycle.
- The block holds a reloadable interval timer with interrupt, the LED output register, the switch input, the 7-segment digit register and a free-running system tick counter.
- Its irqout feeds the CPU control unit's IRQ input, and the CPU vectors to the interrupt handler when it is asserted.

---
 rtl/timer_periph_slave.sv | 161 ++++++++++++++++
 tb/tb_timer_periph_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_periph_slave.sv
// Memory-mapped timer / GPIO responder for the CPU load/store bus.
// Holds a reloadable 32-bit interval timer with a level interrupt, the LED and
// 7-segment output registers, the switch input and a free-running tick counter.
// Reads are combinational (the CPU samples rdata in the same cycle it strobes rd);
// writes land on the rising edge where wr is high.
module timer_periph_slave #(
    parameter int LED_W  = 8,
    parameter int SW_W   = 8,
    parameter int DIGI_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout
);

    // Word index of each register (byte offset / 4); addr[1:0] never decoded.
    localparam logic [5:0] IDX_TH      = 6'h00;
    localparam logic [5:0] IDX_TL      = 6'h01;
    localparam logic [5:0] IDX_TCON    = 6'h02;
    localparam logic [5:0] IDX_LED     = 6'h03;
    localparam logic [5:0] IDX_SWITCH  = 6'h04;
    localparam logic [5:0] IDX_DIGI    = 6'h05;
    localparam logic [5:0] IDX_SYSTICK = 6'h06;

    // TCON bit positions
    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_STAT = 2;

    // Architectural state
    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [2:0]        r_tcon;
    logic [LED_W-1:0]  r_led;
    logic [DIGI_W-1:0] r_digi;
    logic [31:0]       r_systick;

    // Address decode
    logic [5:0] w_idx;
    logic       w_wr_th;
    logic       w_wr_tl;
    logic       w_wr_tcon;
    logic       w_wr_led;
    logic       w_wr_digi;

    // Timer datapath
    logic        w_tl_at_max;
    logic        w_overflow;
    logic        w_irq_hit;
    logic [31:0] w_tl_counted;

    // Only the low byte (minus the byte lane) selects a register.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr[31:8], addr[1:0]};

    assign w_idx     = addr[7:2];
    assign w_wr_th   = wr && (w_idx == IDX_TH);
    assign w_wr_tl   = wr && (w_idx == IDX_TL);
    assign w_wr_tcon = wr && (w_idx == IDX_TCON);
    assign w_wr_led  = wr && (w_idx == IDX_LED);
    assign w_wr_digi = wr && (w_idx == IDX_DIGI);

    // Overflow is the enabled cycle in which TL sits at all-ones; the reload
    // always uses the TH value held before this edge, so a simultaneous TH
    // write only affects the following overflow.
    assign w_tl_at_max  = (r_tl == 32'hFFFF_FFFF);
    assign w_overflow   = r_tcon[TCON_EN] && w_tl_at_max;
    assign w_irq_hit    = w_overflow && r_tcon[TCON_IE];
    assign w_tl_counted = w_overflow ? r_th : (r_tl + 32'd1);

    // TH reload register: plain software register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= '0;
        end else if (w_wr_th) begin
            r_th <= wdata;
        end
    end

    // TL counter: a CPU write beats counting/reload in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= '0;
        end else if (w_wr_tl) begin
            r_tl <= wdata;
        end else if (r_tcon[TCON_EN]) begin
            r_tl <= w_tl_counted;
        end
    end

    // TCON: software owns enable/irq-enable; the status bit is set by hardware
    // on an unmasked overflow and that set wins over a software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= 3'b000;
        end else if (w_wr_tcon) begin
            r_tcon[TCON_EN]   <= wdata[TCON_EN];
            r_tcon[TCON_IE]   <= wdata[TCON_IE];
            r_tcon[TCON_STAT] <= wdata[TCON_STAT] | w_irq_hit;
        end else if (w_irq_hit) begin
            r_tcon[TCON_STAT] <= 1'b1;
        end
    end

    // LED and 7-segment output registers take the low bits of the write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led  <= '0;
            r_digi <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= wdata[LED_W-1:0];
            end
            if (w_wr_digi) begin
                r_digi <= wdata[DIGI_W-1:0];
            end
        end
    end

    // Free-running tick counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // Combinational read mux; narrow registers are zero-extended and idle or
    // unmapped accesses return zero so the CPU bus mux can OR responders.
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (w_idx)
                IDX_TH:      rdata = r_th;
                IDX_TL:      rdata = r_tl;
                IDX_TCON:    rdata[2:0] = r_tcon;
                IDX_LED:     rdata[LED_W-1:0] = r_led;
                IDX_SWITCH:  rdata[SW_W-1:0] = switch;
                IDX_DIGI:    rdata[DIGI_W-1:0] = r_digi;
                IDX_SYSTICK: rdata = r_systick;
                default:     rdata = 32'h0;
            endcase
        end
    end

    assign led    = r_led;
    assign digi   = r_digi;
    // Level interrupt taken straight from registered state: masking with the
    // enable bit hides it without losing the pending status.
    assign irqout = r_tcon[TCON_IE] & r_tcon[TCON_STAT];

endmodule

// File: tb/tb_timer_periph_slave.sv
// Bench for timer_periph_slave: directed scenarios plus a randomized bus phase,
// all compared against a cycle-level behavioural model of the register map.
module tb_timer_periph_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch_in;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_periph_slave #(.LED_W(8), .SW_W(8), .DIGI_W(12)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch_in),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tick = 0; m_tcon = 0; m_led = 0; m_digi = 0;
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
        if (!r) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h00:   return m_th;
            8'h04:   return m_tl;
            8'h08:   return {29'h0, m_tcon};
            8'h0C:   return {24'h0, m_led};
            8'h10:   return {24'h0, switch_in};
            8'h14:   return {20'h0, m_digi};
            8'h18:   return m_tick;
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the register map: timer rules first, then the CPU write.
    task automatic model_clock(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        running = m_tcon[0];
        logic        wrapped = running && (m_tl == 32'hFFFF_FFFF);
        logic        flag    = wrapped && m_tcon[1];
        logic [31:0] tl_new  = !running ? m_tl : (wrapped ? m_th : m_tl + 1);
        logic [2:0]  tc_new  = flag ? (m_tcon | 3'b100) : m_tcon;
        if (w) begin
            case (a[7:0] & 8'hFC)
                8'h00: m_th   = d;
                8'h04: tl_new = d;
                8'h08: tc_new = {d[2] | flag, d[1:0]};
                8'h0C: m_led  = d[7:0];
                8'h14: m_digi = d[11:0];
                default: ;
            endcase
        end
        m_tl   = tl_new;
        m_tcon = tc_new;
        m_tick = m_tick + 1;
    endtask

    // ---------------- bus helpers ----------------
    // One bus cycle, started just after a rising edge.
    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string what);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        check({what, "_rdata"}, rdata, model_read(r, a));
        if (r || w)
            $display("txn %-14s rd=%0b wr=%0b addr=%h wdata=%h rdata=%h", what, r, w, a, d, rdata);
        @(posedge clk);
        model_clock(w, a, d);
        #1;
        rd = 1'b0; wr = 1'b0;
        check({what, "_led"},  {24'h0, led},  {24'h0, m_led});
        check({what, "_digi"}, {20'h0, digi}, {20'h0, m_digi});
        check({what, "_irq"},  {31'h0, irqout}, {31'h0, m_tcon[1] & m_tcon[2]});
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input string what);
        bus(1'b0, 1'b1, a, d, what);
    endtask

    // Compare rdata against a hand-derived constant without advancing time past the edge.
    task automatic peek(input logic r, input logic [31:0] a, input logic [31:0] exp, input string tag);
        rd = r; wr = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp);
        rd = 1'b0;
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string tag);
        peek(1'b1, a, exp, tag);
        bus(1'b1, 1'b0, a, 32'h0, tag);
    endtask

    // Idle until the model says TL holds the target, then confirm on the DUT.
    task automatic wait_tl(input logic [31:0] target);
        for (int n = 0; n < 16 && m_tl != target; n++) idle();
        peek(1'b1, 32'h04, target, "wait_tl");
    endtask

    // Asynchronous reset pulse with a write pending that must not survive.
    task automatic async_reset();
        rd = 1'b0; wr = 1'b1; addr = 32'h0C; wdata = 32'hFF;
        #2;
        reset = 1'b1;
        #1;
        check("rst_led_now",  {24'h0, led}, 32'h0);
        check("rst_digi_now", {20'h0, digi}, 32'h0);
        check("rst_irq_now",  {31'h0, irqout}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_led_hold", {24'h0, led}, 32'h0);
        wr = 1'b0;
        reset = 1'b0;
        $display("txn reset pulse done");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 0; wdata = 0; switch_in = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        read_expect(32'h00, 32'h0, "th_rst");
        read_expect(32'h08, 32'h0, "tcon_rst");
        read_expect(32'h18, 32'h2, "tick_rst");

        // Reset while counting with the interrupt pending
        write(32'h0C, 32'h5A, "led_w");
        write(32'h14, 32'hABC, "digi_w");
        write(32'h04, 32'hFFFF_FFFE, "tl_w");
        write(32'h08, 32'h3, "tcon_w");
        idle(); idle();
        check("irq_pre_reset", {31'h0, irqout}, 32'h1);
        async_reset();
        read_expect(32'h04, 32'h0, "tl_after_rst");
        read_expect(32'h18, 32'h1, "tick_after_rst");

        // Reload and interrupt
        write(32'h00, 32'hFFFF_FFFC, "th_w");
        write(32'h04, 32'hFFFF_FFFE, "tl_w");
        write(32'h08, 32'h3, "tcon_w");
        check("irq_before_ovf", {31'h0, irqout}, 32'h0);
        read_expect(32'h04, 32'hFFFF_FFFE, "tl_a");
        read_expect(32'h04, 32'hFFFF_FFFF, "tl_b");
        check("irq_rise", {31'h0, irqout}, 32'h1);
        read_expect(32'h04, 32'hFFFF_FFFC, "tl_reload");
        idle(); idle();
        check("irq_hold", {31'h0, irqout}, 32'h1);

        // Software clear away from overflow
        wait_tl(32'hFFFF_FFFD);
        write(32'h08, 32'h3, "tcon_clr");
        check("irq_clear", {31'h0, irqout}, 32'h0);
        // Software clear landing on the overflow edge loses to the hardware set
        wait_tl(32'hFFFF_FFFF);
        write(32'h08, 32'h3, "tcon_clr_ovf");
        check("irq_hw_wins", {31'h0, irqout}, 32'h1);
        peek(1'b1, 32'h08, 32'h7, "tcon_hw_wins");

        // TH written on the overflow edge: reload uses old TH
        wait_tl(32'hFFFF_FFFF);
        write(32'h00, 32'hFFFF_FFF0, "th_w_ovf");
        peek(1'b1, 32'h04, 32'hFFFF_FFFC, "tl_old_th");

        // Mask and unmask
        write(32'h08, 32'h5, "tcon_mask");
        check("irq_masked", {31'h0, irqout}, 32'h0);
        read_expect(32'h08, 32'h5, "tcon_masked");
        write(32'h08, 32'h7, "tcon_unmask");
        check("irq_unmask", {31'h0, irqout}, 32'h1);
        write(32'h08, 32'h0, "tcon_off");

        // LED / digi / switch
        write(32'h0C, 32'h1234_56A5, "led_w");
        check("led_val", {24'h0, led}, 32'hA5);
        read_expect(32'h0C, 32'hA5, "led_rd");
        write(32'h14, 32'hFFF, "digi_w");
        check("digi_val", {20'h0, digi}, 32'hFFF);
        switch_in = 8'h3C;
        read_expect(32'h10, 32'h3C, "sw_rd");
        write(32'h10, 32'hFFFF_FFFF, "sw_w");
        read_expect(32'h10, 32'h3C, "sw_ro");
        check("led_unchanged", {24'h0, led}, 32'hA5);

        // Unmapped, idle and address aliasing
        read_expect(32'h1C, 32'h0, "unmapped");
        peek(1'b0, 32'h0C, 32'h0, "rd_low");
        read_expect(32'h4000_000F, 32'hA5, "led_alias");

        // TL holds while disabled
        write(32'h04, 32'h1234_5678, "tl_w_hold");
        for (int i = 0; i < 10; i++) read_expect(32'h04, 32'h1234_5678, "tl_hold");

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            int unsigned idx;
            logic [31:0] a, d;
            logic r, w;
            idx = ($urandom % 4 == 0) ? ($urandom % 64) : ($urandom % 8);
            a = {$urandom, 8'h00} | {24'h0, idx[5:0], 2'b00} | ($urandom % 4);
            r = ($urandom % 2) == 1;
            w = ($urandom % 10) < 3;
            case (idx)
                0, 1:    d = 32'hFFFF_FFF0 + ($urandom % 16);
                2:       d = $urandom % 8;
                default: d = $urandom;
            endcase
            switch_in = 8'($urandom);
            if ($urandom % 250 == 0) async_reset();
            else bus(r, w, a, d, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
